// File: rtl/wb_pkg.sv
// ============================================================================
// Module : wb_pkg
// Brief  : Shared types and constants for the result writeback stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_pkg;

    typedef enum logic [1:0] {
        DST_RD   = 2'b00,
        DST_PAIR = 2'b01,
        DST_PC   = 2'b10,
        DST_NONE = 2'b11
    } dst_sel_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HI   = 1'b1
    } wb_state_t;

    // Low address bits cleared on every PC load (word-aligned fetch)
    localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

endpackage

`default_nettype wire

// File: rtl/result_wb.sv
// ============================================================================
// Module : result_wb
// Brief  : Writeback stage; commits results to the register file or the PC.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module result_wb
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int PC_IDX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        dst_sel,
    input  logic [ADDR_W-1:0] rd_idx,
    input  logic [ADDR_W-1:0] rd_hi_idx,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] result_hi,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_wdata,
    output logic              flush,
    output logic [15:0]       wb_count
);

    wb_state_t         state;
    logic [ADDR_W-1:0] hi_idx;
    logic [DATA_W-1:0] hi_data;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              accept_pair;

    function automatic logic is_pc_alias(input logic [ADDR_W-1:0] idx);
        return idx == ADDR_W'(PC_IDX);
    endfunction

    assign in_ready = (state == S_IDLE);

    // One write per cycle: the pending high word has priority over a new accept
    always_comb begin
        wr_en       = 1'b0;
        wr_idx      = rd_idx;
        wr_data     = result;
        accept_pair = 1'b0;
        if (state == S_HI) begin
            wr_en   = 1'b1;
            wr_idx  = hi_idx;
            wr_data = hi_data;
        end else if (in_valid) begin
            case (dst_sel_t'(dst_sel))
                DST_RD:   wr_en = 1'b1;
                DST_PAIR: begin
                    wr_en       = 1'b1;
                    accept_pair = 1'b1;
                end
                DST_PC: begin
                    wr_en  = 1'b1;
                    wr_idx = ADDR_W'(PC_IDX);
                end
                default:  wr_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            hi_idx   <= '0;
            hi_data  <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            pc_we    <= 1'b0;
            pc_wdata <= '0;
            flush    <= 1'b0;
            wb_count <= '0;
        end else begin
            rf_we <= 1'b0;
            pc_we <= 1'b0;
            flush <= 1'b0;

            if (wr_en) begin
                wb_count <= wb_count + 16'd1;
                if (is_pc_alias(wr_idx)) begin
                    pc_we    <= 1'b1;
                    flush    <= 1'b1;
                    pc_wdata <= wr_data & ~DATA_W'(PC_ALIGN_MASK);
                end else begin
                    rf_we    <= 1'b1;
                    rf_waddr <= wr_idx;
                    rf_wdata <= wr_data;
                end
            end

            case (state)
                S_IDLE: begin
                    if (accept_pair) begin
                        hi_idx  <= rd_hi_idx;
                        hi_data <= result_hi;
                        state   <= S_HI;
                    end
                end
                S_HI:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_result_wb.sv
// ============================================================================
// Module : tb_result_wb
// Brief  : Self-checking bench for result_wb against a write-queue model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_result_wb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  dst_sel = 2'b00;
    logic [3:0]  rd_idx = '0;
    logic [3:0]  rd_hi_idx = '0;
    logic [31:0] result = '0;
    logic [31:0] result_hi = '0;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pc_we;
    logic [31:0] pc_wdata;
    logic        flush;
    logic [15:0] wb_count;

    int vectors = 0;
    int miscompares = 0;

    result_wb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dst_sel  (dst_sel),
        .rd_idx   (rd_idx),
        .rd_hi_idx(rd_hi_idx),
        .result   (result),
        .result_hi(result_hi),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .pc_we    (pc_we),
        .pc_wdata (pc_wdata),
        .flush    (flush),
        .wb_count (wb_count)
    );

    always #5 clk = ~clk;

    // Model: every accepted transaction expands into a list of writes;
    // one write drains per cycle and new accepts only happen when the list is empty.
    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] data;
    } wr_t;

    wr_t         pend[$];
    logic        m_rf_we, m_pc_we, m_ready;
    logic [3:0]  m_rf_waddr;
    logic [31:0] m_rf_wdata, m_pc_wdata;
    logic [15:0] m_count;

    task automatic m_reset();
        pend.delete();
        m_rf_we = 0; m_pc_we = 0; m_ready = 1;
        m_rf_waddr = 0; m_rf_wdata = 0; m_pc_wdata = 0; m_count = 0;
    endtask

    task automatic model_edge();
        wr_t w;
        bit  have = 0;
        if (pend.size() > 0) begin
            w = pend.pop_front();
            have = 1;
        end else if (in_valid) begin
            case (dst_sel)
                2'b00: begin w = '{rd_idx, result}; have = 1; end
                2'b01: begin
                    w = '{rd_idx, result}; have = 1;
                    pend.push_back('{rd_hi_idx, result_hi});
                end
                2'b10: begin w = '{4'd15, result}; have = 1; end
                default: have = 0;
            endcase
        end
        m_rf_we = 0;
        m_pc_we = 0;
        if (have) begin
            m_count = m_count + 1;
            if (w.idx == 4'd15) begin
                m_pc_we = 1;
                m_pc_wdata = {w.data[31:2], 2'b00};
            end else begin
                m_rf_we = 1;
                m_rf_waddr = w.idx;
                m_rf_wdata = w.data;
            end
        end
        m_ready = (pend.size() == 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] d, input logic [3:0] i,
                         input logic [3:0] hi, input logic [31:0] r, input logic [31:0] rh);
        in_valid = v; dst_sel = d; rd_idx = i; rd_hi_idx = hi; result = r; result_hi = rh;
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive(0, 0, 0, 0, 0, 0);
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (rf_we !== 0 || pc_we !== 0 || flush !== 0) begin miscompares++; $display("FAIL reset_strobes: rf_we=%b pc_we=%b flush=%b required all 0", rf_we, pc_we, flush); end
        vectors++; if (rf_waddr !== 0 || rf_wdata !== 0 || pc_wdata !== 0) begin miscompares++; $display("FAIL reset_data: waddr=%h wdata=%h pc=%h required 0", rf_waddr, rf_wdata, pc_wdata); end
        vectors++; if (wb_count !== 0 || in_ready !== 1) begin miscompares++; $display("FAIL reset_cnt_ready: count=%h ready=%b required 0/1", wb_count, in_ready); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_single_rd();
        drive(1, 2'b00, 4'd3, 0, 32'hDEADBEEF, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        vectors++; if (rf_we !== 1 || rf_waddr !== 4'd3 || rf_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_rd: we=%b addr=%h data=%h required 1/3/deadbeef", rf_we, rf_waddr, rf_wdata); end
        vectors++; if (wb_count !== 16'd1 || pc_we !== 0) begin miscompares++; $display("FAIL single_rd_cnt: count=%h pc_we=%b required 1/0", wb_count, pc_we); end
        step();
        vectors++; if (rf_we !== 0 || rf_waddr !== 4'd3 || rf_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_rd_hold: we=%b addr=%h data=%h required 0/3/deadbeef", rf_we, rf_waddr, rf_wdata); end
    endtask

    task automatic test_pair();
        drive(1, 2'b01, 4'd4, 4'd5, 32'h1, 32'h2);
        step();
        vectors++; if (rf_we !== 1 || rf_waddr !== 4'd4 || rf_wdata !== 32'h1 || in_ready !== 0) begin miscompares++; $display("FAIL pair_lo: we=%b addr=%h data=%h ready=%b required 1/4/1/0", rf_we, rf_waddr, rf_wdata, in_ready); end
        // payload changes while stalled must be ignored
        drive(1, 2'b00, 4'd9, 4'd9, 32'h5555, 32'h6666);
        step();
        vectors++; if (rf_we !== 1 || rf_waddr !== 4'd5 || rf_wdata !== 32'h2 || in_ready !== 1) begin miscompares++; $display("FAIL pair_hi: we=%b addr=%h data=%h ready=%b required 1/5/2/1", rf_we, rf_waddr, rf_wdata, in_ready); end
        step();
        drive(0, 0, 0, 0, 0, 0);
        vectors++; if (rf_we !== 1 || rf_waddr !== 4'd9 || rf_wdata !== 32'h5555) begin miscompares++; $display("FAIL pair_next: we=%b addr=%h data=%h required 1/9/5555", rf_we, rf_waddr, rf_wdata); end
        vectors++; if (wb_count !== m_count) begin miscompares++; $display("FAIL pair_cnt: count=%h required %h", wb_count, m_count); end
        step();
    endtask

    task automatic test_pc_alias();
        drive(1, 2'b00, 4'd15, 0, 32'h1003, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        vectors++; if (pc_we !== 1 || flush !== 1 || pc_wdata !== 32'h1000 || rf_we !== 0) begin miscompares++; $display("FAIL pc_alias: pc_we=%b flush=%b pc=%h rf_we=%b required 1/1/1000/0", pc_we, flush, pc_wdata, rf_we); end
        drive(1, 2'b10, 4'd2, 0, 32'hABCD_0007, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        vectors++; if (pc_we !== 1 || pc_wdata !== 32'hABCD_0004 || rf_we !== 0) begin miscompares++; $display("FAIL pc_dst: pc_we=%b pc=%h rf_we=%b required 1/abcd0004/0", pc_we, pc_wdata, rf_we); end
        step();
        vectors++; if (pc_we !== 0 || flush !== 0 || pc_wdata !== 32'hABCD_0004) begin miscompares++; $display("FAIL pc_hold: pc_we=%b flush=%b pc=%h required 0/0/abcd0004", pc_we, flush, pc_wdata); end
    endtask

    task automatic test_pair_pc();
        drive(1, 2'b01, 4'd6, 4'd15, 32'h77, 32'h2002);
        step();
        drive(0, 0, 0, 0, 0, 0);
        vectors++; if (rf_we !== 1 || rf_waddr !== 4'd6 || rf_wdata !== 32'h77 || pc_we !== 0) begin miscompares++; $display("FAIL pair_pc_lo: we=%b addr=%h data=%h pc_we=%b required 1/6/77/0", rf_we, rf_waddr, rf_wdata, pc_we); end
        step();
        vectors++; if (pc_we !== 1 || flush !== 1 || pc_wdata !== 32'h2000 || rf_we !== 0) begin miscompares++; $display("FAIL pair_pc_hi: pc_we=%b flush=%b pc=%h rf_we=%b required 1/1/2000/0", pc_we, flush, pc_wdata, rf_we); end
        // same index for both halves: high word lands last
        drive(1, 2'b01, 4'd7, 4'd7, 32'h11, 32'h22);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        vectors++; if (rf_we !== 1 || rf_waddr !== 4'd7 || rf_wdata !== 32'h22) begin miscompares++; $display("FAIL pair_same: we=%b addr=%h data=%h required 1/7/22", rf_we, rf_waddr, rf_wdata); end
        step();
    endtask

    task automatic test_discard();
        logic [15:0] c0;
        c0 = m_count;
        drive(1, 2'b11, 4'd3, 4'd15, 32'hFFFF_FFFF, 32'h1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        vectors++; if (rf_we !== 0 || pc_we !== 0 || flush !== 0 || wb_count !== c0 || in_ready !== 1) begin miscompares++; $display("FAIL discard: rf_we=%b pc_we=%b flush=%b count=%h ready=%b required 0/0/0/%h/1", rf_we, pc_we, flush, wb_count, in_ready, c0); end
    endtask

    task automatic test_random();
        int errs_before;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom),
                  ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom),
                  $urandom, $urandom);
            step();
            errs_before = miscompares;
            vectors++;
            if (in_ready !== m_ready || rf_we !== m_rf_we || pc_we !== m_pc_we || flush !== m_pc_we)
                miscompares++;
            else if (rf_waddr !== m_rf_waddr || rf_wdata !== m_rf_wdata || pc_wdata !== m_pc_wdata || wb_count !== m_count)
                miscompares++;
            if (miscompares != errs_before)
                $display("FAIL random[%0d]: ready=%b rf=%b/%h/%h pc=%b/%h flush=%b cnt=%h required ready=%b rf=%b/%h/%h pc=%b/%h flush=%b cnt=%h",
                         n, in_ready, rf_we, rf_waddr, rf_wdata, pc_we, pc_wdata, flush, wb_count,
                         m_ready, m_rf_we, m_rf_waddr, m_rf_wdata, m_pc_we, m_pc_wdata, m_pc_we, m_count);
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
    endtask

    task automatic test_reset_in_hi();
        drive(1, 2'b01, 4'd1, 4'd2, 32'hA, 32'hB);
        step();
        drive(0, 0, 0, 0, 0, 0);
        vectors++; if (in_ready !== 0 || rf_we !== 1) begin miscompares++; $display("FAIL rst_hi_pre: ready=%b rf_we=%b required 0/1", in_ready, rf_we); end
        rst_n = 0;
        m_reset();
        #1;
        vectors++; if (rf_we !== 0 || pc_we !== 0 || flush !== 0 || wb_count !== 0 || rf_waddr !== 0 || rf_wdata !== 0 || pc_wdata !== 0 || in_ready !== 1) begin miscompares++; $display("FAIL rst_hi_async: rf=%b/%h/%h pc=%b/%h cnt=%h ready=%b required zeros, ready 1", rf_we, rf_waddr, rf_wdata, pc_we, pc_wdata, wb_count, in_ready); end
        @(negedge clk);
        rst_n = 1;
        step();
        vectors++; if (rf_we !== 0 || pc_we !== 0 || wb_count !== 0 || in_ready !== 1) begin miscompares++; $display("FAIL rst_hi_drop: rf_we=%b pc_we=%b cnt=%h ready=%b required 0/0/0/1", rf_we, pc_we, wb_count, in_ready); end
    endtask

    task automatic test_wrap();
        drive(1, 2'b00, 4'd1, 0, 32'h0, 0);
        for (int n = 0; n < 65535; n++) step();
        vectors++; if (wb_count !== 16'hFFFF || wb_count !== m_count) begin miscompares++; $display("FAIL wrap_pre: count=%h required ffff", wb_count); end
        step();
        drive(0, 0, 0, 0, 0, 0);
        vectors++; if (wb_count !== 16'h0000) begin miscompares++; $display("FAIL wrap: count=%h required 0000", wb_count); end
    endtask

    initial begin
        test_reset();
        test_single_rd();
        test_pair();
        test_pc_alias();
        test_pair_pc();
        test_discard();
        test_random();
        test_reset_in_hi();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/result_wb.md
# result_wb

Writeback stage at the far end of the operand path. It accepts one execute-stage result per handshake and commits it through the single register-file write port, or redirects the PC. Results go to Rd, to an RdLo/RdHi pair (64-bit multiply, two sequenced writes), to the PC, or are discarded. Writes addressed to register index 15 become PC redirects.

## Interface
Parameters:
- DATA_W, 32, datapath width
- ADDR_W, 4, register index width
- PC_IDX, 15, register index aliased to the PC

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  result present
- in_ready  out  1  stage can accept
- dst_sel  in  2  destination: 00 Rd, 01 pair Lo/Hi, 10 PC, 11 discard
- rd_idx  in  ADDR_W  Rd, or RdLo when pair
- rd_hi_idx  in  ADDR_W  RdHi, used only when pair
- result  in  DATA_W  result, or low word when pair
- result_hi  in  DATA_W  high word when pair
- rf_we  out  1  register-file write strobe
- rf_waddr  out  ADDR_W  write index
- rf_wdata  out  DATA_W  write data
- pc_we  out  1  PC load strobe
- pc_wdata  out  DATA_W  PC value, bits [1:0] forced 0
- flush  out  1  pipeline flush, asserted with pc_we
- wb_count  out  16  committed write count (rf_we or pc_we cycles), wraps

## Operation
- Handshake: a transaction is accepted at a rising edge where in_valid && in_ready. in_valid may be held with changing payload while in_ready=0; only the accepted payload is used.
- States: S_IDLE and S_HI.
  - in_ready = (state == S_IDLE).
- S_IDLE, accept:
  - dst 00: if rd_idx != PC_IDX, register rf write {rd_idx, result}. Otherwise register a PC write of result.
  - dst 10: register a PC write of result.
  - dst 11: nothing; no strobes.
  - dst 01: write the low word as for dst 00 using rd_idx. Latch rd_hi_idx and result_hi, then go to S_HI.
- S_HI: issue the high-word write (rf, or PC if rd_hi_idx == PC_IDX) and return to S_IDLE. No accept occurs in this state.
- With rd_idx == rd_hi_idx, both writes occur and the register ends holding the high word.
- PC write: pc_we=1, flush=1, pc_wdata = value & ~3. rf_we=0 that cycle.
- All strobes are single-cycle pulses. rf_waddr, rf_wdata and pc_wdata hold their last values when their strobe is low.
- wb_count increments by 1 per cycle with rf_we || pc_we and wraps 0xFFFF→0.

## Timing
- Latency: accept at edge k → strobe valid in cycle k..k+1 (registered outputs).
- Throughput: 1 transaction/cycle for dst 00/10/11. Pair occupies 2 cycles, in_ready=0 for exactly 1 cycle after a pair accept.
- Back-to-back: a new accept at edge k+1 overwrites outputs with no bubble.
- Reset (async, any time): state=S_IDLE, and all outputs are 0 (rf_we, pc_we, flush, rf_waddr, rf_wdata, pc_wdata, wb_count). in_ready=1 from reset. A pending high-word write is dropped, not replayed.
- Reset release: the first accept can occur at the first rising edge with rst_n=1.

## Structure
- Package wb_pkg holds:
  - enum dst_sel_t {DST_RD, DST_PAIR, DST_PC, DST_NONE}
  - enum wb_state_t {S_IDLE, S_HI}
  - localparam PC_ALIGN_MASK
- Single module; no sub-module is warranted. The PC-alias decode is a local function reused for both low and high writes.

## Test plan
- Reset, then accept dst 00, rd_idx=3, result=0xDEADBEEF → next cycle rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF, wb_count=1.
- Accept dst 01, rd_idx=4, rd_hi_idx=5, result=0x1, result_hi=0x2, in_valid held → cycle 1: write R4=0x1, in_ready=0. Cycle 2: write R5=0x2. Next accept at the following edge.
- Accept dst 00, rd_idx=15, result=0x1003 → pc_we=1, flush=1, pc_wdata=0x1000, rf_we=0.
- Pair with rd_hi_idx=15, result_hi=0x2002 → rf write of low word, then pc_we with 0x2000.
- Accept dst 11 → no strobes and wb_count unchanged. Preset wb_count to 0xFFFF via 65535 writes, then one write → 0x0000.
- Assert rst_n=0 during S_HI → outputs 0 immediately, no high write after release, in_ready=1.
